ntwrk_size_tracker: RTL and testbench



---
 rtl/aoc_types_pkg.sv | 57 +++++
 rtl/ntwrk_top3.sv | 36 +++
 rtl/ntwrk_size_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_ntwrk_size_tracker.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_types_pkg.sv
// Shared command/response types and widths for the network-size tracking pipeline.
// Storage depth and size limit default from NUM_CONNS / NUM_POINTS macros.
`ifndef NUM_CONNS
`define NUM_CONNS 8
`endif
`ifndef NUM_POINTS
`define NUM_POINTS 20
`endif

package aoc_types_pkg;

  localparam int NTWRK_ID_W = $clog2(`NUM_CONNS);
  localparam int SIZE_W     = $clog2(`NUM_POINTS + 1);
  localparam int PROD_W     = 3 * SIZE_W;

  typedef enum logic [2:0] {
    NTWRK_NEW    = 3'd0,
    NTWRK_WR_A   = 3'd1,
    NTWRK_WR_B   = 3'd2,
    NTWRK_MERGE  = 3'd3,
    NTWRK_IGNORE = 3'd4,
    NTWRK_LOOKUP = 3'd5,
    NTWRK_UPDATE = 3'd6
  } ntwrk_cmd_id_t;

  typedef struct packed {
    logic [NTWRK_ID_W-1:0] ntwrkb;
    logic [NTWRK_ID_W-1:0] ntwrka;
    ntwrk_cmd_id_t         cmd;
  } ntwrk_size_cmd_t;

  typedef struct packed {
    logic              is_final;
    logic [PROD_W-1:0] data;
  } ntwrk_size_rsp_t;

  typedef enum logic [2:0] {
    TRK_IDLE,
    TRK_MRG,
    TRK_SCAN,
    TRK_MUL,
    TRK_RSP
  } trk_state_t;

  // Returns {saturated, value}; value is clamped to lim when the sum exceeds it.
  function automatic logic [SIZE_W:0] sat_add(input logic [SIZE_W-1:0] x,
                                              input logic [SIZE_W-1:0] y,
                                              input logic [SIZE_W-1:0] lim);
    logic [SIZE_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s > {1'b0, lim}) begin
      return {1'b1, lim};
    end
    return {1'b0, s[SIZE_W-1:0]};
  endfunction

endpackage

// File: rtl/ntwrk_top3.sv
// Running top-3 of a stream of sizes, kept sorted m0 >= m1 >= m2.
// One compare-and-shift insertion per cycle; clr zeroes all three (zero = empty slot).
module ntwrk_top3
  import aoc_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [SIZE_W-1:0] in_size,
  output logic [SIZE_W-1:0] m0,
  output logic [SIZE_W-1:0] m1,
  output logic [SIZE_W-1:0] m2
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      m0 <= '0;
      m1 <= '0;
      m2 <= '0;
    end else if (in_vld) begin
      // >= so that equal sizes each occupy their own slot
      if (in_size >= m0) begin
        m2 <= m1;
        m1 <= m0;
        m0 <= in_size;
      end else if (in_size >= m1) begin
        m2 <= m1;
        m1 <= in_size;
      end else if (in_size >= m2) begin
        m2 <= in_size;
      end
    end
  end

endmodule

// File: rtl/ntwrk_size_tracker.sv
// Per-network size/valid store answering LOOKUP (1 cycle) and UPDATE (NUM_CONNS+2 cycles, top-3 product).
// cmd_ready only in IDLE; responses held in RSP until rsp_ready, errored commands dropped with sticky err.
module ntwrk_size_tracker
  import aoc_types_pkg::*;
#(
  parameter int NUM_CONNS  = `NUM_CONNS,
  parameter int NUM_POINTS = `NUM_POINTS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [$bits(ntwrk_size_cmd_t)-1:0] cmd,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic                               rsp_final,
  output logic [PROD_W-1:0]                  rsp_data,
  output logic                               err
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(NUM_POINTS);

  trk_state_t        state_q, state_d;
  ntwrk_size_cmd_t   c;
  logic              cmd_fire;
  logic              cmd_err;

  logic [SIZE_W-1:0] size_q [NUM_CONNS];
  logic [NUM_CONNS-1:0] valid_q;

  logic              a_in, a_live, b_live;
  logic [SIZE_W-1:0] size_a, size_b, lookup_size;
  logic [SIZE_W:0]   inc_a, inc_b, sum_ab;

  logic [NTWRK_ID_W-1:0] mrg_a, mrg_b, scan_idx;
  logic [SIZE_W-1:0]     mrg_sum;
  logic                  mrg_ok;
  logic                  scan_last;

  logic                  top_clr, top_vld;
  logic [SIZE_W-1:0]     top_size, m0, m1, m2;
  logic [PROD_W-1:0]     f0, f1, f2, prod;

  ntwrk_size_rsp_t       rsp_q;
  logic                  err_q;

  assign c        = ntwrk_size_cmd_t'(cmd);
  assign cmd_fire = cmd_valid && cmd_ready;

  // Operand decode against the current store.
  assign a_in        = int'(c.ntwrka) < NUM_CONNS;
  assign a_live      = a_in && valid_q[c.ntwrka];
  assign b_live      = (int'(c.ntwrkb) < NUM_CONNS) && valid_q[c.ntwrkb];
  assign size_a      = size_q[c.ntwrka];
  assign size_b      = size_q[c.ntwrkb];
  assign inc_a       = sat_add(size_a, SIZE_W'(1), MAX_SIZE);
  assign inc_b       = sat_add(size_b, SIZE_W'(1), MAX_SIZE);
  assign sum_ab      = sat_add(size_a, size_b, MAX_SIZE);
  assign lookup_size = a_live ? size_a : '0;

  always_comb begin
    cmd_err = 1'b0;
    case (c.cmd)
      NTWRK_NEW:    cmd_err = !a_in || a_live;
      NTWRK_WR_A:   cmd_err = !a_live || inc_a[SIZE_W];
      NTWRK_WR_B:   cmd_err = !b_live || inc_b[SIZE_W];
      NTWRK_MERGE:  cmd_err = (c.ntwrka == c.ntwrkb) || !a_live || !b_live || sum_ab[SIZE_W];
      NTWRK_IGNORE,
      NTWRK_LOOKUP,
      NTWRK_UPDATE: cmd_err = 1'b0;
      default:      cmd_err = 1'b1;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      TRK_IDLE: begin
        if (cmd_fire) begin
          case (c.cmd)
            NTWRK_MERGE:  state_d = TRK_MRG;
            NTWRK_LOOKUP: state_d = TRK_RSP;
            NTWRK_UPDATE: state_d = TRK_SCAN;
            default:      state_d = TRK_IDLE;
          endcase
        end
      end
      TRK_MRG:  state_d = TRK_IDLE;
      TRK_SCAN: state_d = scan_last ? TRK_MUL : TRK_SCAN;
      TRK_MUL:  state_d = TRK_RSP;
      TRK_RSP:  state_d = rsp_ready ? TRK_IDLE : TRK_RSP;
      default:  state_d = TRK_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      TRK_IDLE: cmd_ready = !rst;
      TRK_RSP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Size/valid store. MERGE is committed in MRG from operands latched at accept;
  // nothing else can be accepted in between, so the latched sum is still current.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONNS; i++) begin
        size_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (state_q == TRK_MRG) begin
      if (mrg_ok) begin
        size_q[mrg_a]  <= mrg_sum;
        size_q[mrg_b]  <= '0;
        valid_q[mrg_b] <= 1'b0;
      end
    end else if (cmd_fire && !cmd_err) begin
      case (c.cmd)
        NTWRK_NEW: begin
          size_q[c.ntwrka]  <= SIZE_W'(2);
          valid_q[c.ntwrka] <= 1'b1;
        end
        NTWRK_WR_A: size_q[c.ntwrka] <= inc_a[SIZE_W-1:0];
        NTWRK_WR_B: size_q[c.ntwrkb] <= inc_b[SIZE_W-1:0];
        default:    ;
      endcase
    end
  end

  assign scan_last = int'(scan_idx) == NUM_CONNS - 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      mrg_a    <= '0;
      mrg_b    <= '0;
      mrg_sum  <= '0;
      mrg_ok   <= 1'b0;
      scan_idx <= '0;
      rsp_q    <= '0;
    end else begin
      if (cmd_fire && cmd_err) begin
        err_q <= 1'b1;
      end
      if (cmd_fire) begin
        mrg_a   <= c.ntwrka;
        mrg_b   <= c.ntwrkb;
        mrg_sum <= sum_ab[SIZE_W-1:0];
        mrg_ok  <= !cmd_err;
      end
      if (cmd_fire && c.cmd == NTWRK_LOOKUP) begin
        rsp_q <= '{is_final: 1'b0, data: PROD_W'(lookup_size)};
      end
      if (cmd_fire && c.cmd == NTWRK_UPDATE) begin
        scan_idx <= '0;
      end else if (state_q == TRK_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if (state_q == TRK_MUL) begin
        rsp_q <= '{is_final: 1'b1, data: prod};
      end
    end
  end

  assign top_clr  = cmd_fire && c.cmd == NTWRK_UPDATE;
  assign top_vld  = (state_q == TRK_SCAN) && valid_q[scan_idx];
  assign top_size = size_q[scan_idx];

  ntwrk_top3 u_top3 (
    .clk     (clk),
    .rst     (rst),
    .clr     (top_clr),
    .in_vld  (top_vld),
    .in_size (top_size),
    .m0      (m0),
    .m1      (m1),
    .m2      (m2)
  );

  // Empty slots multiply as 1 so fewer than three networks still give a product.
  assign f0   = (m0 == '0) ? PROD_W'(1) : PROD_W'(m0);
  assign f1   = (m1 == '0) ? PROD_W'(1) : PROD_W'(m1);
  assign f2   = (m2 == '0) ? PROD_W'(1) : PROD_W'(m2);
  assign prod = f0 * f1 * f2;

  assign rsp_final = rsp_q.is_final;
  assign rsp_data  = rsp_q.data;
  assign err       = err_q;

endmodule

// File: tb/tb_ntwrk_size_tracker.sv
// Scenario bench for ntwrk_size_tracker: expected responses are queued at command issue and
// compared when the DUT presents them.
module tb_ntwrk_size_tracker;
  import aoc_types_pkg::*;

  localparam int N    = `NUM_CONNS;
  localparam int MAXP = `NUM_POINTS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [$bits(ntwrk_size_cmd_t)-1:0] cmd = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic rsp_final;
  logic [PROD_W-1:0] rsp_data;
  logic err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [PROD_W:0] exp_q[$];

  ntwrk_size_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_final (rsp_final),
    .rsp_data  (rsp_data),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one command and returns the cycle stamp just after the accepting edge.
  task automatic send(input logic [2:0] op, input int a, input int b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    cmd = {NTWRK_ID_W'(b), NTWRK_ID_W'(a), op};
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout op=%0d cmd_ready=%b required 1", op, cmd_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Collects the next presented response (bounded); v=0 means none arrived.
  task automatic get_rsp(input int lim, output logic v, output logic [PROD_W:0] d, output int at);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    v  = rsp_valid;
    d  = {rsp_final, rsp_data};
    at = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_rst got %b required 0", cmd_ready);
    end
    checks++;
    if ({rsp_valid, rsp_final, rsp_data, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b f=%b d=%0d err=%b required all 0",
               rsp_valid, rsp_final, rsp_data, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_lookup();
    int acc, at;
    logic v;
    logic [PROD_W:0] d, expv;
    do_reset();
    send(NTWRK_NEW, 0, 0, acc);
    send(NTWRK_WR_A, 0, 0, acc);
    send(NTWRK_WR_B, 5, 0, acc);
    send(NTWRK_LOOKUP, 0, 0, acc);
    exp_q.push_back({1'b0, PROD_W'(4)});
    get_rsp(10, v, d, at);
    expv = exp_q.pop_front();
    checks++;
    if (!v || d !== expv || at != acc) begin
      errors++;
      $display("FAIL lookup_basic v=%b f=%b d=%0d lat=%0d required f=%b d=%0d lat=0",
               v, d[PROD_W], d[PROD_W-1:0], at - acc, expv[PROD_W], expv[PROD_W-1:0]);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL lookup_err got %b required 0", err);
    end
  endtask

  task automatic test_merge();
    int acc, acc_m, at;
    logic v;
    logic [PROD_W:0] d, expv;
    do_reset();
    send(NTWRK_NEW, 0, 0, acc);
    send(NTWRK_NEW, 1, 0, acc);
    send(NTWRK_WR_A, 1, 0, acc);
    send(NTWRK_MERGE, 0, 1, acc_m);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL merge_busy cmd_ready=%b required 0", cmd_ready);
    end
    send(NTWRK_LOOKUP, 0, 0, acc);
    exp_q.push_back({1'b0, PROD_W'(5)});
    checks++;
    if (acc != acc_m + 2) begin
      errors++;
      $display("FAIL merge_gap accept gap %0d required 2", acc - acc_m);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        send(NTWRK_LOOKUP, 1, 0, acc);
        exp_q.push_back({1'b0, PROD_W'(0)});
      end
      get_rsp(10, v, d, at);
      expv = exp_q.pop_front();
      checks++;
      if (!v || d !== expv || at != acc) begin
        errors++;
        $display("FAIL merge_lookup%0d v=%b d=%0d lat=%0d required d=%0d lat=0",
                 k, v, d[PROD_W-1:0], at - acc, expv[PROD_W-1:0]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL merge_err got %b required 0", err);
    end
  endtask

  task automatic test_update();
    int acc, at;
    int wr_cnt[5] = '{3, 2, 0, 0, 1};
    logic v;
    logic [PROD_W:0] d, expv;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(NTWRK_NEW, i, 0, acc);
      for (int j = 0; j < wr_cnt[i]; j++) send(NTWRK_WR_A, i, 0, acc);
    end
    send(NTWRK_UPDATE, 0, 0, acc);
    exp_q.push_back({1'b1, PROD_W'(60)});
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL update_early rsp_valid=%b at +%0d required 0", rsp_valid, N);
    end
    get_rsp(10, v, d, at);
    expv = exp_q.pop_front();
    checks++;
    if (!v || d !== expv || at != acc + N + 1) begin
      errors++;
      $display("FAIL update_top3 v=%b f=%b d=%0d lat=%0d required f=1 d=%0d lat=%0d",
               v, d[PROD_W], d[PROD_W-1:0], at - acc, expv[PROD_W-1:0], N + 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_final, rsp_data} !== {1'b1, expv}) begin
        errors++;
        $display("FAIL update_hold%0d v=%b f=%b d=%0d required v=1 f=1 d=%0d",
                 k, rsp_valid, rsp_final, rsp_data, expv[PROD_W-1:0]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL update_release v=%b ready=%b required v=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_update_edges();
    int acc, at;
    logic v;
    logic [PROD_W:0] d, expv;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      if (k == 0) begin
        send(NTWRK_NEW, 3, 0, acc);
        exp_q.push_back({1'b1, PROD_W'(2)});
      end else begin
        exp_q.push_back({1'b1, PROD_W'(1)});
      end
      send(NTWRK_UPDATE, 0, 0, acc);
      get_rsp(N + 10, v, d, at);
      expv = exp_q.pop_front();
      checks++;
      if (!v || d !== expv || at != acc + N + 1) begin
        errors++;
        $display("FAIL update_edge%0d v=%b f=%b d=%0d lat=%0d required f=1 d=%0d lat=%0d",
                 k, v, d[PROD_W], d[PROD_W-1:0], at - acc, expv[PROD_W-1:0], N + 1);
      end
    end
  endtask

  task automatic test_errors();
    int acc, at;
    logic v;
    logic [PROD_W:0] d, expv;
    logic [2:0] bad_op;
    // {setup id, setup WR_A count, bad op, bad a, bad b, lookup id, lookup size}
    int tab[4][7] = '{'{0, 0, 1, 7, 0, 7, 0},
                      '{2, 0, 3, 2, 2, 2, 2},
                      '{1, 1, 0, 1, 0, 1, 3},
                      '{4, 0, 7, 4, 4, 4, 2}};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      send(NTWRK_NEW, tab[k][0], 0, acc);
      for (int j = 0; j < tab[k][1]; j++) send(NTWRK_WR_A, tab[k][0], 0, acc);
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_clean%0d err=%b required 0", k, err);
      end
      bad_op = 3'(tab[k][2]);
      send(bad_op, tab[k][3], tab[k][4], acc);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL err_set%0d err=%b required 1", k, err);
      end
      send(NTWRK_LOOKUP, tab[k][5], 0, acc);
      exp_q.push_back({1'b0, PROD_W'(tab[k][6])});
      get_rsp(10, v, d, at);
      expv = exp_q.pop_front();
      checks++;
      if (!v || d !== expv || err !== 1'b1) begin
        errors++;
        $display("FAIL err_state%0d v=%b d=%0d err=%b required d=%0d err=1",
                 k, v, d[PROD_W-1:0], err, expv[PROD_W-1:0]);
      end
    end
  endtask

  task automatic test_rst_mid_scan();
    int acc, at;
    logic v, seen;
    logic [PROD_W:0] d, expv;
    do_reset();
    send(NTWRK_NEW, 0, 0, acc);
    send(NTWRK_UPDATE, 0, 0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_scan_ready got %b required 1", cmd_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan_rsp rsp_valid rose=%b required 0", seen);
    end
    send(NTWRK_LOOKUP, 0, 0, acc);
    exp_q.push_back({1'b0, PROD_W'(0)});
    get_rsp(10, v, d, at);
    expv = exp_q.pop_front();
    checks++;
    if (!v || d !== expv || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan_lookup v=%b d=%0d err=%b required d=0 err=0", v, d[PROD_W-1:0], err);
    end
  endtask

  task automatic test_back_to_back();
    int acc, prev, at;
    logic v;
    logic [PROD_W:0] d, expv;
    do_reset();
    send(NTWRK_NEW, 6, 0, prev);
    for (int j = 0; j < MAXP - 2; j++) begin
      send(NTWRK_WR_A, 6, 0, acc);
      checks++;
      if (acc != prev + 1) begin
        errors++;
        $display("FAIL b2b_gap%0d accept gap %0d required 1", j, acc - prev);
      end
      prev = acc;
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err_at_max err=%b required 0", err);
    end
    send(NTWRK_WR_A, 6, 0, acc);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_saturate_err err=%b required 1", err);
    end
    send(NTWRK_LOOKUP, 6, 0, acc);
    exp_q.push_back({1'b0, PROD_W'(MAXP)});
    get_rsp(10, v, d, at);
    expv = exp_q.pop_front();
    checks++;
    if (!v || d !== expv) begin
      errors++;
      $display("FAIL b2b_lookup v=%b d=%0d required d=%0d", v, d[PROD_W-1:0], expv[PROD_W-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_merge();
    test_update();
    test_update_edges();
    test_errors();
    test_rst_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
